helper_axis_burst_generator: RTL and testbench

HELPER_AXIS_BURST_GENERATOR -- requirements
Module: helper_axis_burst_generator

---
 rtl/helper_axis_pkg.sv | 23 ++
 rtl/helper_lfsr.sv | 26 ++
 rtl/helper_axis_burst_generator.sv | 143 ++++++++++++++
 tb/tb_helper_axis_burst_generator.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/helper_axis_pkg.sv
// Shared types and constants for the AXI-Stream burst generator and its LFSR helper.
package helper_axis_pkg;

    typedef enum logic [1:0] {
        MODE_COUNTER,
        MODE_LFSR,
        MODE_CONSTANT
    } mode_e;

    typedef enum logic [1:0] {
        StIdle,
        StOffer,
        StDone
    } state_e;

    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    // Right-shifting Galois step: feedback taps applied when bit 0 shifts out.
    function automatic logic [31:0] lfsr_step(input logic [31:0] state);
        return state[0] ? ((state >> 1) ^ LFSR_POLY) : (state >> 1);
    endfunction

endpackage

// File: rtl/helper_lfsr.sv
// 32-bit Galois LFSR with synchronous reload to SEED and an advance enable.
module helper_lfsr
    import helper_axis_pkg::*;
#(
    parameter logic [31:0] SEED      = 32'h1,
    parameter int unsigned OUT_WIDTH = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_advance,
    output logic [OUT_WIDTH-1:0] o_data
);

    logic [31:0] r_state;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= SEED;
        end else if (i_advance) begin
            r_state <= lfsr_step(r_state);
        end
    end

    assign o_data = r_state[OUT_WIDTH-1:0];

endmodule

// File: rtl/helper_axis_burst_generator.sv
// AXI-Stream beat source: counter, LFSR or constant data with periodic last,
// optional beat limit and optional pseudo-random idle gaps.
module helper_axis_burst_generator
    import helper_axis_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 10,
    parameter mode_e       MODE         = MODE_COUNTER,
    parameter logic [31:0] START_VALUE  = 32'd0,
    parameter logic [31:0] STEP         = 32'd1,
    parameter logic [31:0] SEED         = 32'h1,
    parameter logic [31:0] BEAT_LIMIT   = 32'd0,
    parameter logic [15:0] LAST_PERIOD  = 16'd16,
    parameter bit          STALL_RANDOM = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    output logic                  output_valid,
    output logic [DATA_WIDTH-1:0] output_data,
    output logic                  output_last,
    input  logic                  output_ready,
    output logic                  done,
    output logic [31:0]           beats_sent
);

    // The gate LFSR must never be seeded with zero.
    localparam logic [31:0] STALL_SEED = (~SEED == 32'd0) ? 32'h1 : ~SEED;

    state_e                r_state, w_state_next;
    logic                  r_valid, w_valid_next;
    logic                  r_last, w_last_next;
    logic                  r_done, w_done_next;
    logic [DATA_WIDTH-1:0] r_data, w_data_next;
    logic [31:0]           r_beats, w_beats_next;
    logic [15:0]           r_period, w_period_next;
    logic                  w_hs;
    logic                  w_gate;
    logic                  w_stall_bit;
    logic [DATA_WIDTH-1:0] w_lfsr_data;

    function automatic logic last_of(input logic [15:0] period, input logic [31:0] idx);
        return (period + 16'd1 == LAST_PERIOD) ||
               ((BEAT_LIMIT != 32'd0) && (idx == BEAT_LIMIT - 32'd1));
    endfunction

    helper_lfsr #(
        .SEED      (SEED),
        .OUT_WIDTH (DATA_WIDTH)
    ) u_data_lfsr (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_advance (w_hs),
        .o_data    (w_lfsr_data)
    );

    helper_lfsr #(
        .SEED      (STALL_SEED),
        .OUT_WIDTH (1)
    ) u_stall_lfsr (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_advance (1'b1),
        .o_data    (w_stall_bit)
    );

    assign w_hs   = r_valid & output_ready;
    assign w_gate = STALL_RANDOM ? w_stall_bit : 1'b1;

    always_comb begin
        w_state_next  = r_state;
        w_valid_next  = r_valid;
        w_last_next   = r_last;
        w_done_next   = r_done;
        w_data_next   = r_data;
        w_beats_next  = r_beats;
        w_period_next = r_period;
        case (r_state)
            StIdle: begin
                if (enable && w_gate) begin
                    w_state_next = StOffer;
                    w_valid_next = 1'b1;
                    w_last_next  = last_of(r_period, r_beats);
                end
            end
            StOffer: begin
                if (w_hs) begin
                    w_beats_next  = (r_beats == 32'hFFFF_FFFF) ? r_beats : r_beats + 32'd1;
                    w_period_next = r_last ? 16'd0 : r_period + 16'd1;
                    if (MODE == MODE_COUNTER) begin
                        w_data_next = r_data + STEP[DATA_WIDTH-1:0];
                    end
                    if ((BEAT_LIMIT != 32'd0) && (w_beats_next == BEAT_LIMIT)) begin
                        w_state_next = StDone;
                        w_valid_next = 1'b0;
                        w_last_next  = 1'b0;
                        w_done_next  = 1'b1;
                    end else if (enable && w_gate) begin
                        w_last_next = last_of(w_period_next, w_beats_next);
                    end else begin
                        w_state_next = StIdle;
                        w_valid_next = 1'b0;
                        w_last_next  = 1'b0;
                    end
                end
            end
            StDone: begin
            end
            default: begin
                w_state_next = StIdle;
                w_valid_next = 1'b0;
                w_last_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= StIdle;
            r_valid  <= 1'b0;
            r_last   <= 1'b0;
            r_done   <= 1'b0;
            r_data   <= START_VALUE[DATA_WIDTH-1:0];
            r_beats  <= 32'd0;
            r_period <= 16'd0;
        end else begin
            r_state  <= w_state_next;
            r_valid  <= w_valid_next;
            r_last   <= w_last_next;
            r_done   <= w_done_next;
            r_data   <= w_data_next;
            r_beats  <= w_beats_next;
            r_period <= w_period_next;
        end
    end

    // The LFSR state is itself a register, so data stays stable while offered.
    assign output_data  = (MODE == MODE_LFSR) ? w_lfsr_data : r_data;
    assign output_valid = r_valid;
    assign output_last  = r_last;
    assign done         = r_done;
    assign beats_sent   = r_beats;

endmodule

// File: tb/tb_helper_axis_burst_generator.sv
// Directed bench: counter with limit/period, LFSR data, and randomly stalled counter.
module tb_helper_axis_burst_generator;
    import helper_axis_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Counter instance: 4-bit, starts at 14, 7 beats, last every 3rd beat.
    logic        a_rst, a_enable, a_ready, a_valid, a_last, a_done;
    logic [3:0]  a_data;
    logic [31:0] a_beats;
    // LFSR instance: 32-bit data, seed 1, unlimited.
    logic        l_rst, l_enable, l_ready, l_valid, l_last, l_done;
    logic [31:0] l_data;
    logic [31:0] l_beats;
    // Stalled counter instance: 10-bit, random idle gaps.
    logic        s_rst, s_enable, s_ready, s_valid, s_last, s_done;
    logic [9:0]  s_data;
    logic [31:0] s_beats;

    helper_axis_burst_generator #(
        .DATA_WIDTH (4), .MODE (MODE_COUNTER), .START_VALUE (32'd14), .STEP (32'd1),
        .BEAT_LIMIT (32'd7), .LAST_PERIOD (16'd3)
    ) u_a (
        .clk (clk), .rst (a_rst), .enable (a_enable), .output_valid (a_valid),
        .output_data (a_data), .output_last (a_last), .output_ready (a_ready),
        .done (a_done), .beats_sent (a_beats)
    );

    helper_axis_burst_generator #(
        .DATA_WIDTH (32), .MODE (MODE_LFSR), .SEED (32'h1)
    ) u_l (
        .clk (clk), .rst (l_rst), .enable (l_enable), .output_valid (l_valid),
        .output_data (l_data), .output_last (l_last), .output_ready (l_ready),
        .done (l_done), .beats_sent (l_beats)
    );

    helper_axis_burst_generator #(
        .DATA_WIDTH (10), .MODE (MODE_COUNTER), .SEED (32'h1234_5678),
        .LAST_PERIOD (16'd16), .STALL_RANDOM (1'b1)
    ) u_s (
        .clk (clk), .rst (s_rst), .enable (s_enable), .output_valid (s_valid),
        .output_data (s_data), .output_last (s_last), .output_ready (s_ready),
        .done (s_done), .beats_sent (s_beats)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          beats;
        int          cyc;
        logic [9:0]  exp_data;
        logic        pv;
        logic        acc;
        logic [9:0]  pd;

        a_rst = 1'b1; a_enable = 1'b0; a_ready = 1'b0;
        l_rst = 1'b1; l_enable = 1'b0; l_ready = 1'b0;
        s_rst = 1'b1; s_enable = 1'b0; s_ready = 1'b0;
        tick();
        tick();
        a_rst = 1'b0; l_rst = 1'b0; s_rst = 1'b0;

        check("rst_valid", a_valid, 0);
        check("rst_data", a_data, 14);
        check("rst_last", a_last, 0);
        check("rst_done", a_done, 0);
        check("rst_beats", a_beats, 0);
        check("rst_lfsr_data", l_data, 32'h1);
        check("rst_stall_valid", s_valid, 0);

        // Back-to-back counter beats with wrap
        a_enable = 1'b1; a_ready = 1'b1;
        tick();
        check("b0_valid", a_valid, 1);
        check("b0_data", a_data, 14);
        check("b0_last", a_last, 0);
        tick();
        check("b1_data", a_data, 15);
        check("b1_last", a_last, 0);
        tick();
        check("b2_data", a_data, 0);
        check("b2_last", a_last, 1);
        tick();
        check("b3_data", a_data, 1);
        check("b3_last", a_last, 0);
        check("b3_beats", a_beats, 3);

        // Sink back-pressure with enable dropped: beat 3 must hold
        a_ready = 1'b0; a_enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_valid", a_valid, 1);
            check("hold_data", a_data, 1);
            check("hold_last", a_last, 0);
            check("hold_beats", a_beats, 3);
        end
        a_ready = 1'b1;
        tick();
        check("accept_to_idle_valid", a_valid, 0);
        check("accept_beats", a_beats, 4);

        a_enable = 1'b1;
        tick();
        check("b4_data", a_data, 2);
        check("b4_last", a_last, 0);
        tick();
        check("b5_data", a_data, 3);
        check("b5_last", a_last, 1);
        tick();
        check("b6_data", a_data, 4);
        check("b6_last", a_last, 1);
        tick();
        check("done_valid", a_valid, 0);
        check("done_flag", a_done, 1);
        check("done_beats", a_beats, 7);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("done_stay_valid", a_valid, 0);
            check("done_stay_flag", a_done, 1);
        end

        // Reset during OFFER, then reset colliding with a handshake
        a_enable = 1'b0; a_ready = 1'b0; a_rst = 1'b1;
        tick();
        a_rst = 1'b0;
        check("rerst_done", a_done, 0);
        check("rerst_beats", a_beats, 0);
        a_enable = 1'b1;
        tick();
        check("offer_valid", a_valid, 1);
        a_rst = 1'b1;
        tick();
        check("rst_offer_valid", a_valid, 0);
        check("rst_offer_beats", a_beats, 0);
        a_rst = 1'b0;
        tick();
        check("offer2_valid", a_valid, 1);
        a_ready = 1'b1; a_rst = 1'b1;
        tick();
        check("rst_hs_valid", a_valid, 0);
        check("rst_hs_beats", a_beats, 0);
        a_rst = 1'b0;
        tick();
        check("post_rst_valid", a_valid, 1);
        check("post_rst_data", a_data, 14);
        tick();
        check("post_rst_beats", a_beats, 1);
        check("post_rst_data1", a_data, 15);
        a_enable = 1'b0; a_ready = 1'b0;

        // LFSR reference: 1, 80200003, c0300002, 60180001
        l_enable = 1'b1; l_ready = 1'b1;
        tick();
        check("lfsr_b0", l_data, 32'h0000_0001);
        tick();
        check("lfsr_b1", l_data, 32'h8020_0003);
        tick();
        check("lfsr_b2", l_data, 32'hC030_0002);
        tick();
        check("lfsr_b3", l_data, 32'h6018_0001);
        check("lfsr_beats", l_beats, 3);
        check("lfsr_last", l_last, 0);
        check("lfsr_done", l_done, 0);
        check("lfsr_valid", l_valid, 1);
        l_enable = 1'b0; l_ready = 1'b0;

        // Random gaps and random ready: valid never drops without acceptance
        s_enable = 1'b1;
        beats = 0;
        cyc = 0;
        exp_data = 10'd0;
        while (beats < 1000 && cyc < 20000) begin
            s_ready = ($urandom_range(3) != 0);
            acc = s_valid && s_ready;
            if (acc) begin
                check("stall_data", s_data, exp_data);
                check("stall_last", s_last, (exp_data[3:0] == 4'hf));
                exp_data = exp_data + 10'd1;
                beats++;
            end
            pv = s_valid;
            pd = s_data;
            tick();
            cyc++;
            if (pv && !acc) begin
                check("stall_hold_valid", s_valid, 1);
                check("stall_hold_data", s_data, pd);
            end
        end
        check("stall_beats", s_beats, 1000);
        check("stall_done", s_done, 0);
        s_enable = 1'b0; s_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
